// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg : shared constants and helpers for the multi-port register file
// Revision     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package reg_file_pkg;

  localparam int IMG_DEPTH = 16;

  localparam logic [7:0] DEFAULT_IMAGE [IMG_DEPTH] = '{
    8'd0,  8'd5,  8'd4,  8'd14, 8'd15, 8'd25, 8'd18, 8'd20,
    8'd8,  8'd13, 8'd9,  8'd11, 8'd12, 8'd26, 8'd18, 8'd1
  };

  // Reset value of register idx, masked to data_w bits; entries past the image are 0.
  function automatic logic [31:0] init_val(input int idx, input int data_w, input bit init_mode);
    logic [31:0] v;
    v = '0;
    if (init_mode && idx >= 0 && idx < IMG_DEPTH) begin
      v = {24'd0, DEFAULT_IMAGE[idx[3:0]]};
    end
    if (data_w < 32) begin
      v = v & ((32'd1 << data_w) - 32'd1);
    end
    return v;
  endfunction

  // LSB position of lane p in a flattened bus of w-bit lanes.
  function automatic int lane_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_rd_port.sv
// ---------------------------------------------------------------------------
// reg_file_rd_port : one registered read port with write bypass and busy check
// Revision         : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file_rd_port #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              busy_bit,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_busy
);

  logic              hit;
  logic              is_zero;
  logic              blocked;
  logic [DATA_W-1:0] rd_data_d,  rd_data_q;
  logic              rd_valid_d, rd_valid_q;
  logic              rd_busy_d,  rd_busy_q;

  always_comb begin
    hit        = wr_en && (wr_addr == rd_addr);
    is_zero    = (R0_ZERO != 0) && (rd_addr == '0);
    // A same-cycle write to the reserved register satisfies the reservation.
    blocked    = busy_bit && !hit && !is_zero;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_busy_d  = 1'b0;
    if (rd_en) begin
      if (blocked) begin
        rd_busy_d = 1'b1;
      end else begin
        rd_valid_d = 1'b1;
        if (is_zero) begin
          rd_data_d = '0;
        end else if (hit) begin
          rd_data_d = wr_data;
        end else begin
          rd_data_d = rd_word;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_busy_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_busy  = rd_busy_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp : multi-read-port register file with bypass and busy scoreboard
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 2,
  parameter int R0_ZERO   = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     res_en,
  input  logic [ADDR_W-1:0]        res_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_d, busy_q;
  logic              wr_ok;
  logic              res_ok;

  // Writes and reservations aimed at a hard-wired zero R0 are dropped here.
  assign wr_ok  = wr_en  && !((R0_ZERO != 0) && (wr_addr  == '0));
  assign res_ok = res_en && !((R0_ZERO != 0) && (res_addr == '0));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Reservation is applied after the clear so a same-address pair stays busy.
    if (res_ok) begin
      busy_d[res_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(init_val(i, DATA_W, INIT_MODE != 0));
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr[lane_lsb(p, ADDR_W) +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .R0_ZERO (R0_ZERO)
    ) u_rd_port (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en[p]),
      .rd_addr  (port_addr),
      .rd_word  (regs_q[port_addr]),
      .busy_bit (busy_q[port_addr]),
      .wr_en    (wr_ok),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[lane_lsb(p, DATA_W) +: DATA_W]),
      .rd_valid (rd_valid[p]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp : directed self-checking bench for reg_file_mp
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_en = '0;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        res_en = 1'b0;
  logic [3:0]  res_addr = '0;
  logic [15:0] busy_vec;

  int vecs = 0;
  int errs = 0;

  reg_file_mp #(
    .DATA_W(8), .ADDR_W(4), .NUM_RD(2), .R0_ZERO(1), .INIT_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .res_en(res_en), .res_addr(res_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en  = '0;
    wr_en  = 1'b0;
    res_en = 1'b0;
  endtask

  task automatic test_reset();
    vecs++; if (rd_valid !== 2'b00) begin errs++; $display("FAIL reset_valid got %b exp %b", rd_valid, 2'b00); end
    vecs++; if (rd_busy !== 2'b00) begin errs++; $display("FAIL reset_busy got %b exp %b", rd_busy, 2'b00); end
    vecs++; if (rd_data !== 16'h0000) begin errs++; $display("FAIL reset_data got %h exp %h", rd_data, 16'h0000); end
    vecs++; if (busy_vec !== 16'h0000) begin errs++; $display("FAIL reset_busy_vec got %h exp %h", busy_vec, 16'h0000); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_init_read();
    rd_en = 2'b11; rd_addr = {4'd15, 4'd3};
    tick();
    vecs++; if (rd_data !== {8'd1, 8'd14}) begin errs++; $display("FAIL init_r3_r15 got %h exp %h", rd_data, {8'd1, 8'd14}); end
    vecs++; if (rd_valid !== 2'b11) begin errs++; $display("FAIL init_valid got %b exp %b", rd_valid, 2'b11); end
    rd_addr = {4'd5, 4'd13};
    tick();
    vecs++; if (rd_data !== {8'd25, 8'd26}) begin errs++; $display("FAIL init_r13_r5 got %h exp %h", rd_data, {8'd25, 8'd26}); end
    idle();
    tick();
    vecs++; if (rd_valid !== 2'b00) begin errs++; $display("FAIL no_req_valid got %b exp %b", rd_valid, 2'b00); end
    vecs++; if (rd_data !== {8'd25, 8'd26}) begin errs++; $display("FAIL no_req_hold got %h exp %h", rd_data, {8'd25, 8'd26}); end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hA7;
    rd_en = 2'b11; rd_addr = {4'd5, 4'd5};
    tick();
    vecs++; if (rd_data !== 16'hA7A7) begin errs++; $display("FAIL bypass_data got %h exp %h", rd_data, 16'hA7A7); end
    vecs++; if (rd_valid !== 2'b11) begin errs++; $display("FAIL bypass_valid got %b exp %b", rd_valid, 2'b11); end
    wr_en = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
    tick();
    vecs++; if (rd_data[7:0] !== 8'hA7) begin errs++; $display("FAIL after_write_data got %h exp %h", rd_data[7:0], 8'hA7); end
    idle();
  endtask

  task automatic test_r0_zero();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h55;
    rd_en = 2'b01; rd_addr = 8'h00;
    tick();
    vecs++; if (rd_data[7:0] !== 8'h00) begin errs++; $display("FAIL r0_bypass_data got %h exp %h", rd_data[7:0], 8'h00); end
    wr_en = 1'b0; res_en = 1'b1; res_addr = 4'd0;
    tick();
    vecs++; if (rd_data[7:0] !== 8'h00) begin errs++; $display("FAIL r0_read_data got %h exp %h", rd_data[7:0], 8'h00); end
    vecs++; if (rd_valid[0] !== 1'b1) begin errs++; $display("FAIL r0_read_valid got %b exp %b", rd_valid[0], 1'b1); end
    vecs++; if (busy_vec !== 16'h0000) begin errs++; $display("FAIL r0_reserve got %h exp %h", busy_vec, 16'h0000); end
    res_en = 1'b0; rd_addr = 8'h00;
    tick();
    vecs++; if (rd_valid[0] !== 1'b1 || rd_busy[0] !== 1'b0) begin errs++; $display("FAIL r0_after_res got v%b b%b exp v1 b0", rd_valid[0], rd_busy[0]); end
    idle();
  endtask

  task automatic test_reserve();
    res_en = 1'b1; res_addr = 4'd7;
    rd_en = 2'b01; rd_addr = {4'd0, 4'd1};
    tick();
    vecs++; if (rd_data[7:0] !== 8'd5) begin errs++; $display("FAIL res_cycle_read got %h exp %h", rd_data[7:0], 8'd5); end
    vecs++; if (busy_vec !== 16'h0080) begin errs++; $display("FAIL res_busy_vec got %h exp %h", busy_vec, 16'h0080); end
    res_en = 1'b0; rd_addr = {4'd0, 4'd7};
    tick();
    vecs++; if (rd_valid[0] !== 1'b0 || rd_busy[0] !== 1'b1) begin errs++; $display("FAIL res_stall got v%b b%b exp v0 b1", rd_valid[0], rd_busy[0]); end
    vecs++; if (rd_data[7:0] !== 8'd5) begin errs++; $display("FAIL res_stall_hold got %h exp %h", rd_data[7:0], 8'd5); end
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    tick();
    vecs++; if (rd_valid[0] !== 1'b1 || rd_data[7:0] !== 8'h3C) begin errs++; $display("FAIL res_write_bypass got v%b d%h exp v1 d3c", rd_valid[0], rd_data[7:0]); end
    vecs++; if (busy_vec !== 16'h0000) begin errs++; $display("FAIL res_cleared got %h exp %h", busy_vec, 16'h0000); end
    wr_en = 1'b0;
    tick();
    vecs++; if (rd_valid[0] !== 1'b1 || rd_data[7:0] !== 8'h3C || rd_busy[0] !== 1'b0) begin errs++; $display("FAIL res_read_after got v%b b%b d%h exp v1 b0 d3c", rd_valid[0], rd_busy[0], rd_data[7:0]); end
    idle();
  endtask

  task automatic test_same_cycle();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h11;
    res_en = 1'b1; res_addr = 4'd9;
    tick();
    vecs++; if (busy_vec !== 16'h0200) begin errs++; $display("FAIL same_busy_vec got %h exp %h", busy_vec, 16'h0200); end
    wr_en = 1'b0; res_en = 1'b1; res_addr = 4'd9;
    rd_en = 2'b01; rd_addr = {4'd3, 4'd9};
    tick();
    vecs++; if (rd_busy !== 2'b01 || rd_valid !== 2'b00) begin errs++; $display("FAIL same_read_busy got b%b v%b exp b01 v00", rd_busy, rd_valid); end
    vecs++; if (busy_vec !== 16'h0200) begin errs++; $display("FAIL rereserve got %h exp %h", busy_vec, 16'h0200); end
    res_en = 1'b0; rd_en = 2'b10;
    tick();
    vecs++; if (rd_data[15:8] !== 8'd14 || rd_valid !== 2'b10) begin errs++; $display("FAIL other_port got d%h v%b exp d0e v10", rd_data[15:8], rd_valid); end
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h22; rd_en = 2'b00;
    tick();
    vecs++; if (busy_vec !== 16'h0000) begin errs++; $display("FAIL same_clear got %h exp %h", busy_vec, 16'h0000); end
    idle();
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hFF;
    res_en = 1'b1; res_addr = 4'd4;
    rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
    tick();
    vecs++; if (rd_valid[0] !== 1'b1 || rd_data[7:0] !== 8'hFF) begin errs++; $display("FAIL pre_rst got v%b d%h exp v1 dff", rd_valid[0], rd_data[7:0]); end
    vecs++; if (busy_vec !== 16'h0010) begin errs++; $display("FAIL pre_rst_busy got %h exp %h", busy_vec, 16'h0010); end
    wr_en = 1'b0; res_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    vecs++; if (rd_valid !== 2'b00) begin errs++; $display("FAIL async_rst_valid got %b exp %b", rd_valid, 2'b00); end
    vecs++; if (busy_vec !== 16'h0000 || rd_data !== 16'h0000) begin errs++; $display("FAIL async_rst_state got busy %h data %h exp 0 0", busy_vec, rd_data); end
    tick();
    vecs++; if (rd_valid !== 2'b00) begin errs++; $display("FAIL rst_held_valid got %b exp %b", rd_valid, 2'b00); end
    rst = 1'b0;
    rd_en = 2'b11; rd_addr = {4'd4, 4'd2};
    tick();
    vecs++; if (rd_data !== {8'd15, 8'd4}) begin errs++; $display("FAIL post_rst_data got %h exp %h", rd_data, {8'd15, 8'd4}); end
    vecs++; if (rd_valid !== 2'b11 || rd_busy !== 2'b00) begin errs++; $display("FAIL post_rst_flags got v%b b%b exp v11 b00", rd_valid, rd_busy); end
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_init_read();
    test_bypass();
    test_r0_zero();
    test_reserve();
    test_same_cycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Clocked, parametrised multi-read-port register file for the mini processor datapath, the successor to the single-port combinational register file. It provides NUM_RD registered read ports, one synchronous write port with write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard. The scoreboard lets the control unit reserve a destination register and stall reads of it until the write lands. It sits between the decoder/control FSM and the ALU operand muxes.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 4, address width; NREGS = 2**ADDR_W registers
NUM_RD, 2, number of independent read ports (1..4)
R0_ZERO, 1, 1: R0 reads 0, and writes and reservations to R0 are ignored
INIT_MODE, 1, 0: all registers reset to 0; 1: registers reset to the package default image

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*ADDR_W  port p address in bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data per port
rd_valid  out  NUM_RD  rd_data for port p valid this cycle
rd_busy  out  NUM_RD  port p request hit a reserved register; data not valid
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
res_en  in  1  reserve (mark busy) register res_addr
res_addr  in  ADDR_W  register to reserve
busy_vec  out  NREGS  current scoreboard, bit i = R[i] reserved

Behaviour:
- Reset (async, rst=1): the register array loads the reset image; rd_data=0, rd_valid=0, rd_busy=0, busy_vec=0. INIT_MODE=1 image (R0..R15): 0,5,4,14,15,25,18,20,8,13,9,11,12,26,18,1; for NREGS>16, the entries above 15 are 0. INIT_MODE=0: all 0.
- Write: on a clk edge with wr_en=1, R[wr_addr] <= wr_data, except when R0_ZERO=1 and wr_addr=0.
- Read latency is 1 cycle. On edge t with rd_en[p]=1, the following are registered and visible after edge t:
  - busy_vec[a]=1 (pre-edge value, after the bypass rule below) -> rd_valid[p]=0, rd_busy[p]=1, rd_data[p] holds its previous value.
  - otherwise rd_valid[p]=1, rd_busy[p]=0, rd_data[p]=R[a].
- rd_en[p]=0 -> rd_valid[p]=0, rd_busy[p]=0, rd_data[p] held.
- Bypass: a same-cycle wr_en to the same address (not suppressed R0) returns wr_data, not the old value. It also counts as not busy for that read, because the write satisfies the reservation.
- R0_ZERO=1, a=0: always rd_data=0, rd_valid=1.
- All ports are independent. Identical addresses on several ports return identical data.
- Scoreboard per edge:
  - wr_en clears busy[wr_addr], then res_en sets busy[res_addr].
  - Same address in the same cycle: the bit ends at 1 (new reservation wins).
  - res_en to an already-busy register: the bit stays 1 (no count).
  - Writes to a non-busy register are legal.
  - R0_ZERO=1: reservations to R0 are ignored, so busy_vec[0] stays 0.
- Reset mid-operation: everything returns to the reset image immediately. Pending reservations are dropped, and an in-flight read produces no valid.
- Out-of-range addresses cannot occur (NREGS = 2**ADDR_W).

Decomposition:
- Package reg_file_pkg holds:
  - the DEFAULT_IMAGE constant array (16 x 8-bit)
  - function init_val(idx, DATA_W, INIT_MODE)
  - localparam helpers for slicing flattened port buses
- One natural sub-module, reg_file_rd_port: one registered read port containing the bypass mux, busy check, and valid/busy flops. It is instantiated NUM_RD times via generate.
- The array and scoreboard live in the top level.

Test Plan:
- Reset, INIT_MODE=1, NUM_RD=2: read R3 on port0 and R15 on port1 in the same cycle -> one cycle later rd_data = 14 / 1, rd_valid = 2'b11.
- Write R5=0xA7 with a same-cycle port0 read of R5 -> next cycle rd_data0 = 0xA7 (bypass). The following-cycle read also returns 0xA7.
- R0_ZERO=1: write R0=0x55, then read R0 -> rd_data=0, rd_valid=1. res_en on R0 -> busy_vec[0]=0.
- Reserve R7, then read R7 -> rd_valid=0, rd_busy=1, busy_vec[7]=1. Write R7=0x3C -> busy_vec[7]=0, and a read of R7 returns 0x3C with rd_valid=1.
- Same cycle: wr_en R9=0x11 and res_en R9 -> busy_vec[9]=1. Reading R9 next cycle gives rd_busy=1.
- Assert rst mid-sequence after writing R2=0xFF and reserving R4 -> R2 reads 4, busy_vec=0, and rd_valid drops asynchronously.
